// File: rtl/lockin_fifo_pkg.sv
// Shared types and widths for the lock-in sample FIFO.
// LOCKIN_FIFO_TIMESTAMP_EN adds a 32-bit cycle timestamp to each stored sample.
package lockin_fifo_pkg;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned SEQ_W  = 8;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned TS_W   = 32;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
`ifdef LOCKIN_FIFO_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } sample_t;

endpackage

// File: rtl/lockin_fifo_mem.sv
// Sample storage: synchronous write, asynchronous read (maps to distributed RAM).
module lockin_fifo_mem
  import lockin_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  sample_t       wdata_i,
  input  logic [AW-1:0] raddr_i,
  output sample_t       rdata_o
);

  sample_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/lockin_sample_fifo.sv
// Sequence-tagged FIFO between the lock-in stage and software, with first-word fall-through.
// Define LOCKIN_FIFO_TIMESTAMP_EN to store a free-running cycle count with each sample (ts_o).
module lockin_sample_fifo #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned SEQ_W  = 8,
  parameter int unsigned DEPTH  = 64,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned PW    = AW + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_tick_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] y_i,
  input  logic                     rd_req_i,
  input  logic                     clr_ovf_i,
`ifdef LOCKIN_FIFO_TIMESTAMP_EN
  output logic [31:0]              ts_o,
`endif
  output logic [31:0]              x_o,
  output logic [31:0]              y_o,
  output logic                     valid_o,
  output logic [PW-1:0]            level_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o
);

  import lockin_fifo_pkg::*;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SEQ_W-1:0]  seq_q;
  logic              rd_req_q;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              valid_q;
  sample_t           head_q, head_d, wr_sample, rd_sample;
  logic              empty, full, pop, push, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = rd_req_i && !rd_req_q && !empty;
  // A pop in the same cycle frees the slot, so a tick into a full FIFO is not dropped.
  assign push  = wr_tick_i && (!full || pop);
  assign drop  = wr_tick_i && full && !pop;

  assign wr_ptr_d = wr_ptr_q + PW'(push);
  assign rd_ptr_d = rd_ptr_q + PW'(pop);

`ifdef LOCKIN_FIFO_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  assign wr_sample = '{seq: seq_q, x: x_i, y: y_i, ts: ts_q};
  assign ts_o      = head_q.ts;
`else
  assign wr_sample = '{seq: seq_q, x: x_i, y: y_i};
`endif

  lockin_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_sample),
    .raddr_i (rd_ptr_d[AW-1:0]),
    .rdata_o (rd_sample)
  );

  // Next head: bypass the write data when the entry being written becomes the head.
  always_comb begin
    head_d = head_q;
    if (wr_ptr_d != rd_ptr_d) begin
      head_d = (push && (rd_ptr_d == wr_ptr_q)) ? wr_sample : rd_sample;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf_i) begin
        drop_cnt_d = DROP_W'(1);
      end else if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end else if (clr_ovf_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      seq_q      <= '0;
      rd_req_q   <= 1'b1;  // a request held across reset must fall before it can pop
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      valid_q    <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      seq_q      <= seq_q + SEQ_W'(wr_tick_i);
      rd_req_q   <= rd_req_i;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      valid_q    <= (wr_ptr_d != rd_ptr_d);
      head_q     <= head_d;
    end
  end

  assign x_o        = {head_q.seq, head_q.x};
  assign y_o        = {head_q.seq, head_q.y};
  assign valid_o    = valid_q;
  assign level_o    = wr_ptr_q - rd_ptr_q;
  assign full_o     = full;
  assign overflow_o = overflow_q;
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_lockin_sample_fifo.sv
// Directed self-checking bench for lockin_sample_fifo (DEPTH=64).
module tb_lockin_sample_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_tick;
  logic [23:0] x_in, y_in;
  logic        rd_req;
  logic        clr_ovf;
  logic [31:0] x_o, y_o;
  logic        valid_o;
  logic [6:0]  level_o;
  logic        full_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;
`ifdef LOCKIN_FIFO_TIMESTAMP_EN
  logic [31:0] ts_o;
  logic [31:0] ts0;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lockin_sample_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .wr_tick_i  (wr_tick),
    .x_i        (x_in),
    .y_i        (y_in),
    .rd_req_i   (rd_req),
    .clr_ovf_i  (clr_ovf),
`ifdef LOCKIN_FIFO_TIMESTAMP_EN
    .ts_o       (ts_o),
`endif
    .x_o        (x_o),
    .y_o        (y_o),
    .valid_o    (valid_o),
    .level_o    (level_o),
    .full_o     (full_o),
    .overflow_o (overflow_o),
    .drop_cnt_o (drop_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] xv, input logic [23:0] yv);
    x_in    = xv;
    y_in    = yv;
    wr_tick = 1'b1;
    step();
    wr_tick = 1'b0;
  endtask

  task automatic pop();
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    step();
  endtask

  initial begin
    reset   = 1'b1;
    wr_tick = 1'b0;
    x_in    = '0;
    y_in    = '0;
    rd_req  = 1'b0;
    clr_ovf = 1'b0;
    step();
    step();
    reset = 1'b0;

    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_x", x_o, 32'h0);
    check("rst_y", y_o, 32'h0);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_drop", 32'(drop_cnt_o), 32'd0);

    push(24'd100, 24'hFFFFFF);
    push(24'hFFFFFB, 24'd2);
    push(24'h7FFFFF, 24'd3);
    check("p3_x", x_o, 32'h00000064);
    check("p3_y", y_o, 32'h00FFFFFF);
    check("p3_level", 32'(level_o), 32'd3);
    check("p3_valid", 32'(valid_o), 32'd1);

    pop();
    check("pop1_x", x_o, 32'h01FFFFFB);
    check("pop1_y", y_o, 32'h01000002);
    check("pop1_level", 32'(level_o), 32'd2);
    pop();
    check("pop2_x", x_o, 32'h027FFFFF);
    check("pop2_y", y_o, 32'h02000003);
    pop();
    check("pop3_valid", 32'(valid_o), 32'd0);
    check("pop3_level", 32'(level_o), 32'd0);
    check("pop3_hold", x_o, 32'h027FFFFF);
    pop();
    check("pop4_level", 32'(level_o), 32'd0);
    push(24'd7, 24'd7);
    check("after_empty_pop_x", x_o, 32'h03000007);
    check("after_empty_pop_level", 32'(level_o), 32'd1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 66; i++) push(24'(i), 24'(i));
    check("ovf_full", 32'(full_o), 32'd1);
    check("ovf_flag", 32'(overflow_o), 32'd1);
    check("ovf_drop", 32'(drop_cnt_o), 32'd2);
    check("ovf_level", 32'(level_o), 32'd64);
    for (int i = 0; i < 64; i++) begin
      check("drain_head", x_o, {8'(i), 24'(i)});
      pop();
    end
    check("drain_valid", 32'(valid_o), 32'd0);
    push(24'h123456, 24'd0);
    check("seq_after_drop", x_o, 32'h42123456);

    for (int i = 0; i < 63; i++) push(24'(i), 24'(i));
    check("refill_full", 32'(full_o), 32'd1);
    rd_req  = 1'b1;
    wr_tick = 1'b1;
    x_in    = 24'hABCDEF;
    step();
    rd_req  = 1'b0;
    wr_tick = 1'b0;
    step();
    check("pushpop_level", 32'(level_o), 32'd64);
    check("pushpop_drop", 32'(drop_cnt_o), 32'd2);
    check("pushpop_head", x_o, 32'h43000000);

    rd_req = 1'b1;
    repeat (10) step();
    rd_req = 1'b0;
    step();
    check("held_level", 32'(level_o), 32'd63);
    check("held_head", x_o, 32'h44000001);

    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow_o), 32'd0);
    check("clr_drop", 32'(drop_cnt_o), 32'd0);
    push(24'd1, 24'd1);
    clr_ovf = 1'b1;
    wr_tick = 1'b1;
    step();
    clr_ovf = 1'b0;
    wr_tick = 1'b0;
    check("clr_vs_drop_ovf", 32'(overflow_o), 32'd1);
    check("clr_vs_drop_cnt", 32'(drop_cnt_o), 32'd1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 5; i++) push(24'(i), 24'(i));
    check("pre_rst_level", 32'(level_o), 32'd5);
    rd_req = 1'b1;
    reset  = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    check("mid_rst_level", 32'(level_o), 32'd0);
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    push(24'd9, 24'd9);
    step();
    step();
    check("held_req_no_pop", 32'(level_o), 32'd1);
    rd_req = 1'b0;
    step();
    rd_req = 1'b1;
    step();
    check("retoggle_pop", 32'(level_o), 32'd0);
    rd_req = 1'b0;
    step();

`ifdef LOCKIN_FIFO_TIMESTAMP_EN
    push(24'd1, 24'd1);
    ts0 = ts_o;
    repeat (36) step();
    push(24'd2, 24'd2);
    check("ts_head_hold", ts_o, ts0);
    pop();
    check("ts_delta", ts_o - ts0, 32'd37);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
